gpio_edge_irq: RTL and testbench

GPIO_EDGE_IRQ -- requirements
Module: gpio_edge_irq

---
 rtl/gpio_irq_pkg.sv | 19 +
 rtl/gpio_debounce.sv | 41 ++++
 rtl/gpio_edge_irq.sv | 74 +++++++
 tb/tb_gpio_edge_irq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: register map, word indices and shared types for gpio_edge_irq
package gpio_irq_pkg;
  localparam logic [31:0] OFF_PEND  = 32'h00;
  localparam logic [31:0] OFF_IEN   = 32'h04;
  localparam logic [31:0] OFF_RISE  = 32'h08;
  localparam logic [31:0] OFF_FALL  = 32'h0C;
  localparam logic [31:0] OFF_LEVEL = 32'h10;
  localparam logic [2:0] IDX_PEND  = 3'd0;
  localparam logic [2:0] IDX_IEN   = 3'd1;
  localparam logic [2:0] IDX_RISE  = 3'd2;
  localparam logic [2:0] IDX_FALL  = 3'd3;
  localparam logic [2:0] IDX_LEVEL = 3'd4;
  localparam int CNT_W = $clog2(65536);
  typedef struct packed {
    logic       valid;
    logic       write;
    logic [2:0] idx;
  } bus_cap_t;
endpackage

// File: rtl/gpio_debounce.sv
// gpio_debounce: per-pin 2-flop synchronizer, optional debounce (GPIO_IRQ_DEBOUNCE_EN) and edge detect
module gpio_debounce
  import gpio_irq_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);
  logic s1_q, s2_q, stable_q;
`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic stable_d, prev_q, hit;
  assign hit = cnt_q == CNT_W'(DEB_CYCLES - 1);
  // count consecutive cycles where the synchronized level disagrees with the stable level
  always_comb begin
    cnt_d    = (s2_q == stable_q || hit) ? '0 : cnt_q + CNT_W'(1);
    stable_d = (s2_q != stable_q && hit) ? s2_q : stable_q;
  end
  // synchronizer, debounce state and previous stable level for edge detection
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) {s1_q, s2_q, stable_q, prev_q, cnt_q} <= '0;
    else {s1_q, s2_q, stable_q, prev_q, cnt_q} <= {pin_i, s1_q, stable_d, stable_q, cnt_d};
  assign rise_o = stable_q & ~prev_q;
  assign fall_o = ~stable_q & prev_q;
`else
  logic [CNT_W-1:0] unused_deb;
  assign unused_deb = CNT_W'(DEB_CYCLES);
  // synchronizer followed by a plain level register; edges are seen as sync2 leaves stable
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) {s1_q, s2_q, stable_q} <= '0;
    else {s1_q, s2_q, stable_q} <= {pin_i, s1_q, s2_q};
  assign rise_o = s2_q & ~stable_q;
  assign fall_o = ~s2_q & stable_q;
`endif
  assign level_o = stable_q;
endmodule

// File: rtl/gpio_edge_irq.sv
// gpio_edge_irq: AHB-Lite GPIO edge interrupt controller; debounce enabled by GPIO_IRQ_DEBOUNCE_EN
module gpio_edge_irq
  import gpio_irq_pkg::*;
#(
  parameter int PIN_NUM    = 32,
  parameter int DEB_CYCLES = 16
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic               HREADYOUT,
  output logic [31:0]        HRDATA,
  output logic               HRESP,
  input  logic [PIN_NUM-1:0] pin_in,
  output logic               irq
);
  bus_cap_t cap_q, cap_d;
  logic [PIN_NUM-1:0] pend_q, pend_d, ien_q, ien_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
  logic [PIN_NUM-1:0] level, rise, fall, wdat, rd_sel;
  logic irq_q, irq_d, we, unused_bus;
  assign unused_bus = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};
  assign HREADYOUT = 1'b1;
  assign HRESP = 1'b0;
  assign irq = irq_q;
  assign we = cap_q.valid & cap_q.write & HREADY;
  assign wdat = HWDATA[PIN_NUM-1:0];
  for (genvar i = 0; i < PIN_NUM; i++) begin : g_pin
    gpio_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .HCLK(HCLK), .HRESETn(HRESETn), .pin_i(pin_in[i]),
      .level_o(level[i]), .rise_o(rise[i]), .fall_o(fall[i])
    );
  end
  // address-phase capture, register writes and W1C with set-wins pending logic
  always_comb begin
    cap_d = HREADY ? bus_cap_t'{valid: HSEL & HTRANS[1], write: HWRITE, idx: HADDR[4:2]} : cap_q;
    ien_d = (we && cap_q.idx == IDX_IEN) ? wdat : ien_q;
    rise_en_d = (we && cap_q.idx == IDX_RISE) ? wdat : rise_en_q;
    fall_en_d = (we && cap_q.idx == IDX_FALL) ? wdat : fall_en_q;
    pend_d = (pend_q & ~((we && cap_q.idx == IDX_PEND) ? wdat : '0)) | (rise & rise_en_q) | (fall & fall_en_q);
    irq_d = |(pend_q & ien_q);
  end
  // data-phase read mux; zero unless the captured transfer was a valid read
  always_comb begin
    rd_sel = cap_q.idx == IDX_PEND ? pend_q :
             cap_q.idx == IDX_IEN ? ien_q :
             cap_q.idx == IDX_RISE ? rise_en_q :
             cap_q.idx == IDX_FALL ? fall_en_q :
             cap_q.idx == IDX_LEVEL ? level : '0;
    HRDATA = '0;
    HRDATA[PIN_NUM-1:0] = (cap_q.valid & ~cap_q.write) ? rd_sel : '0;
  end
  // state registers
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      cap_q <= '0;
      pend_q <= '0;
      ien_q <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cap_q <= cap_d;
      pend_q <= pend_d;
      ien_q <= ien_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      irq_q <= irq_d;
    end
endmodule

// File: tb/tb_gpio_edge_irq.sv
// tb_gpio_edge_irq: directed table-driven bench for gpio_edge_irq
module tb_gpio_edge_irq;
  import gpio_irq_pkg::*;
  localparam int PN = 8;
  localparam int DEB = 16;
`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 3;
`endif
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  logic HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0, HREADY = 1'b1;
  logic HREADYOUT, HRESP, irq;
  logic [31:0] HADDR = '0, HWDATA = '0, HRDATA, rd;
  logic [1:0] HTRANS = 2'b00;
  logic [PN-1:0] pin_in = '0;
  int n_err = 0, n_chk = 0;
  vec_t vec [23];

  always #5 HCLK = ~HCLK;

  gpio_edge_irq #(.PIN_NUM(PN), .DEB_CYCLES(DEB)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRDATA(HRDATA), .HRESP(HRESP), .pin_in(pin_in), .irq(irq)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = a;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    tick();
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = a;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec[0]  = '{1'b0, OFF_PEND,  32'h0, 32'h0};
    vec[1]  = '{1'b0, OFF_IEN,   32'h0, 32'h0};
    vec[2]  = '{1'b0, OFF_RISE,  32'h0, 32'h0};
    vec[3]  = '{1'b0, OFF_FALL,  32'h0, 32'h0};
    vec[4]  = '{1'b0, OFF_LEVEL, 32'h0, 32'h0};
    vec[5]  = '{1'b1, OFF_IEN,   32'hFFFF_FFFF, 32'h0};
    vec[6]  = '{1'b0, OFF_IEN,   32'h0, 32'hFF};
    vec[7]  = '{1'b1, OFF_RISE,  32'h5A, 32'h0};
    vec[8]  = '{1'b0, OFF_RISE,  32'h0, 32'h5A};
    vec[9]  = '{1'b1, OFF_FALL,  32'h1A5, 32'h0};
    vec[10] = '{1'b0, OFF_FALL,  32'h0, 32'hA5};
    vec[11] = '{1'b1, 32'h18,    32'hFFFF_FFFF, 32'h0};
    vec[12] = '{1'b0, 32'h18,    32'h0, 32'h0};
    vec[13] = '{1'b0, 32'h14,    32'h0, 32'h0};
    vec[14] = '{1'b0, 32'h1C,    32'h0, 32'h0};
    vec[15] = '{1'b0, OFF_RISE,  32'h0, 32'h5A};
    vec[16] = '{1'b0, OFF_FALL,  32'h0, 32'hA5};
    vec[17] = '{1'b1, OFF_PEND,  32'hFF, 32'h0};
    vec[18] = '{1'b0, OFF_PEND,  32'h0, 32'h0};
    vec[19] = '{1'b0, 32'h24,    32'h0, 32'hFF};
    vec[20] = '{1'b1, OFF_IEN,   32'h0, 32'h0};
    vec[21] = '{1'b1, OFF_RISE,  32'h0, 32'h0};
    vec[22] = '{1'b1, OFF_FALL,  32'h0, 32'h0};

    tick(2);
    check("reset_hrdata", HRDATA, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    check("hreadyout", 32'(HREADYOUT), 32'h1);
    check("hresp", 32'(HRESP), 32'h0);
    HRESETn = 1'b1;
    tick();

    foreach (vec[i]) begin
      if (vec[i].wr) bus_write(vec[i].addr, vec[i].wdata);
      else begin
        bus_read(vec[i].addr, rd);
        check($sformatf("vec%0d", i), rd, vec[i].exp);
      end
    end
    bus_read(OFF_IEN, rd);
    check("ien_cleared", rd, 32'h0);

    // rising edge on pin 0: exact latency from pin change to PEND and irq
    bus_write(OFF_RISE, 32'h1);
    bus_write(OFF_IEN, 32'h1);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = OFF_PEND;
    tick();
    pin_in[0] = 1'b1;
    tick(LAT - 1);
    check("pend_early", HRDATA, 32'h0);
    check("irq_early", 32'(irq), 32'h0);
    tick();
    check("pend_on_time", HRDATA, 32'h1);
    check("irq_lag", 32'(irq), 32'h0);
    tick();
    check("irq_on_time", 32'(irq), 32'h1);
    HSEL = 1'b0; HTRANS = 2'b00;
    tick();
    bus_write(OFF_PEND, 32'h1);
    check("irq_after_w1c", 32'(irq), 32'h1);
    tick();
    check("irq_drop_w1c", 32'(irq), 32'h0);
    bus_read(OFF_PEND, rd);
    check("pend_w1c", rd, 32'h0);
    bus_read(OFF_LEVEL, rd);
    check("level_pin0", rd, 32'h1);

`ifdef GPIO_IRQ_DEBOUNCE_EN
    // short glitch on pin 3 must not change the debounced level
    bus_write(OFF_RISE, 32'h9);
    pin_in[3] = 1'b1;
    tick(10);
    pin_in[3] = 1'b0;
    tick(DEB + 6);
    bus_read(OFF_LEVEL, rd);
    check("glitch_level", rd, 32'h1);
    bus_read(OFF_PEND, rd);
    check("glitch_pend", rd, 32'h0);
    check("glitch_irq", 32'(irq), 32'h0);
`endif

    // falling edge on pin 7 with interrupt disabled, then enable and clear
    bus_write(OFF_RISE, 32'h1);
    bus_write(OFF_FALL, 32'h80);
    bus_write(OFF_IEN, 32'h0);
    pin_in[7] = 1'b1;
    tick(LAT + 2);
    pin_in[7] = 1'b0;
    tick(LAT + 2);
    bus_read(OFF_PEND, rd);
    check("fall_pend", rd, 32'h80);
    check("fall_irq_masked", 32'(irq), 32'h0);
    bus_write(OFF_IEN, 32'h80);
    check("ien_irq_lag", 32'(irq), 32'h0);
    tick();
    check("ien_irq_on", 32'(irq), 32'h1);
    bus_write(OFF_PEND, 32'h80);
    check("w1c_irq_hold", 32'(irq), 32'h1);
    tick();
    check("w1c_irq_off", 32'(irq), 32'h0);
    bus_read(OFF_PEND, rd);
    check("fall_pend_clr", rd, 32'h0);

    // W1C colliding with a fresh rise on pin 2: set wins
    bus_write(OFF_RISE, 32'h4);
    pin_in[2] = 1'b1;
    tick(LAT + 2);
    bus_read(OFF_PEND, rd);
    check("rise2_pend", rd, 32'h4);
    pin_in[2] = 1'b0;
    tick(LAT + 2);
    bus_read(OFF_PEND, rd);
    check("fall2_ignored", rd, 32'h4);
    pin_in[2] = 1'b1;
    tick(LAT - 2);
    bus_write(OFF_PEND, 32'h4);
    bus_read(OFF_PEND, rd);
    check("set_wins", rd, 32'h4);
    bus_write(OFF_PEND, 32'h4);
    bus_read(OFF_PEND, rd);
    check("w1c_after", rd, 32'h0);

    // all pins high
    pin_in = 8'hFF;
    tick(LAT + 2);
    bus_read(OFF_LEVEL, rd);
    check("level_all", rd, 32'hFF);
    bus_read(OFF_PEND, rd);
    check("pend_rise_masked", rd, 32'h0);

    // reset with irq high, mid-synchronization and mid-transfer
    bus_write(OFF_FALL, 32'hFF);
    bus_write(OFF_IEN, 32'hFF);
    pin_in = 8'h00;
    tick(LAT + 2);
    check("pre_reset_irq", 32'(irq), 32'h1);
    pin_in = 8'h01;
    tick();
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = OFF_FALL;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'hAA;
    HRESETn = 1'b0;
    #1;
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    tick(2);
    HRESETn = 1'b1;
    bus_write(OFF_RISE, 32'h1);
    bus_write(OFF_IEN, 32'h1);
    bus_read(OFF_FALL, rd);
    check("abort_fall", rd, 32'h0);
    tick(LAT + 2);
    bus_read(OFF_PEND, rd);
    check("post_rst_rise", rd, 32'h1);
    check("post_rst_irq", 32'(irq), 32'h1);
    bus_read(OFF_LEVEL, rd);
    check("post_rst_level", rd, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
